character_motion: RTL and testbench

- Consumes the four collision flag buses (down/up/left/right) produced by the character/platform collision block.
- Produces the character x/y position that drives that block, closing the loop.
- Once per frame tick, applies player input, gravity and a jump arc.
- Waits a settle window after each move so the flags reflect the new position before the next decision.

---
 rtl/char_motion_pkg.sv | 44 ++++
 rtl/motion_settle_timer.sv | 74 +++++++
 rtl/character_motion.sv | 229 ++++++++++++++++++++++
 tb/tb_character_motion.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_motion_pkg.sv
// ============================================================================
// Module      : char_motion_pkg
// Description : Shared types and default constants for the character motion
//               block: vertical state encoding, bus widths, step sizes and
//               playfield bounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package char_motion_pkg;

    // Bus widths
    localparam int POS_W    = 9;   // x/y position width
    localparam int FLAG_W   = 3;   // collision flag bus width
    localparam int JCNT_W   = 5;   // jump tick counter width
    localparam int SETTLE_W = 3;   // settle counter width

    // Vertical motion states
    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } vstate_e;

    // Default positions, steps and bounds
    localparam logic [POS_W-1:0]    X_INIT_DEF     = 9'd20;
    localparam logic [POS_W-1:0]    Y_INIT_DEF     = 9'd100;
    localparam logic [POS_W-1:0]    X_STEP_DEF     = 9'd1;
    localparam logic [POS_W-1:0]    RISE_STEP_DEF  = 9'd2;
    localparam logic [POS_W-1:0]    FALL_STEP_DEF  = 9'd2;
    localparam logic [JCNT_W-1:0]   JUMP_TICKS_DEF = 5'd12;
    localparam logic [POS_W-1:0]    X_MIN_DEF      = 9'd4;
    localparam logic [POS_W-1:0]    X_MAX_DEF      = 9'd308;
    localparam logic [POS_W-1:0]    Y_MAX_DEF      = 9'd226;
    localparam logic [SETTLE_W-1:0] SETTLE_DEF     = 3'd2;

    // A direction is blocked when any bit of its flag bus is set
    function automatic logic is_solid(input logic [FLAG_W-1:0] flags);
        return |flags;
    endfunction

endpackage

`default_nettype wire

// File: rtl/motion_settle_timer.sv
// ============================================================================
// Module      : motion_settle_timer
// Description : Frame tick gate. Holds the post-move settle counter, a single
//               pending-tick slot and the sticky overrun flag. go_o marks the
//               clock on which the motion logic commits a tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motion_settle_timer
    import char_motion_pkg::*;
#(
    parameter logic [SETTLE_W-1:0] SETTLE = SETTLE_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic moved_i,     // the tick being committed changes x or y
    output logic go_o,
    output logic settling_o,
    output logic overrun_o
);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;

    assign settling_o = (cnt_q != '0);
    // A stored tick takes priority; a fresh tick only goes when nothing waits
    assign go_o       = ~settling_o & (pending_q | tick_i);
    assign overrun_o  = overrun_q;

    // Next-state for counter, pending slot and overrun flag
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (go_o && moved_i) begin
            cnt_d = SETTLE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        // A tick that cannot go now is parked; with the slot full it is lost
        if (tick_i && (settling_o || pending_q)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (go_o && pending_q) begin
            pending_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/character_motion.sv
// ============================================================================
// Module      : character_motion
// Description : Character position controller. Once per accepted frame tick
//               applies left/right input, gravity and a jump arc against the
//               collision flags, then lets the flags settle before the next
//               decision.
// Options     : CHARACTER_MOTION_DOUBLE_JUMP_EN - allow one extra jump while
//               airborne (re-armed on landing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module character_motion
    import char_motion_pkg::*;
#(
    parameter logic [POS_W-1:0]    X_INIT     = X_INIT_DEF,
    parameter logic [POS_W-1:0]    Y_INIT     = Y_INIT_DEF,
    parameter logic [POS_W-1:0]    X_STEP     = X_STEP_DEF,
    parameter logic [POS_W-1:0]    RISE_STEP  = RISE_STEP_DEF,
    parameter logic [POS_W-1:0]    FALL_STEP  = FALL_STEP_DEF,
    parameter logic [JCNT_W-1:0]   JUMP_TICKS = JUMP_TICKS_DEF,
    parameter logic [POS_W-1:0]    X_MIN      = X_MIN_DEF,
    parameter logic [POS_W-1:0]    X_MAX      = X_MAX_DEF,
    parameter logic [POS_W-1:0]    Y_MAX      = Y_MAX_DEF,
    parameter logic [SETTLE_W-1:0] SETTLE     = SETTLE_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              tick,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              jump,
    input  logic [FLAG_W-1:0] character_down,
    input  logic [FLAG_W-1:0] character_up,
    input  logic [FLAG_W-1:0] character_left,
    input  logic [FLAG_W-1:0] character_right,
    output logic [POS_W-1:0]  character_x_position,
    output logic [POS_W-1:0]  character_y_position,
    output logic              airborne,
    output logic              landed,
    output logic              settling,
    output logic              tick_overrun
);

    // One extra bit of headroom so bound checks never wrap
    localparam logic [POS_W:0] X_STEP_EXT = {1'b0, X_STEP};
    localparam logic [POS_W:0] X_LEFT_LIM = {1'b0, X_MIN} + {1'b0, X_STEP};
    localparam logic [POS_W:0] X_MAX_EXT  = {1'b0, X_MAX};
    localparam logic [POS_W:0] Y_MAX_EXT  = {1'b0, Y_MAX};
    localparam logic [POS_W:0] FALL_EXT   = {1'b0, FALL_STEP};

    logic [POS_W-1:0]  x_q, x_d, x_mv;
    logic [POS_W-1:0]  y_q, y_d, y_mv;
    vstate_e           state_q, state_d, state_mv;
    logic [JCNT_W-1:0] jump_cnt_q, jump_cnt_d, jump_cnt_mv;
    logic              jump_prev_q, jump_prev_d;
    logic              landed_q, landed_d, land_mv;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
    logic              air_used_q, air_used_d, air_used_mv;
`endif

    logic             down_s, up_s, left_s, right_s;
    logic             jump_edge;
    logic             go;
    logic             moved;
    logic [POS_W:0]   x_ext;
    logic [POS_W:0]   y_fall_ext;
    logic [POS_W-1:0] y_rise;

    assign down_s    = is_solid(character_down);
    assign up_s      = is_solid(character_up);
    assign left_s    = is_solid(character_left);
    assign right_s   = is_solid(character_right);
    assign jump_edge = jump & ~jump_prev_q;

    assign x_ext      = {1'b0, x_q};
    assign y_fall_ext = {1'b0, y_q} + FALL_EXT;
    assign y_rise     = (y_q >= RISE_STEP) ? (y_q - RISE_STEP) : '0;

    // Tick gating, settle counter and overrun tracking
    motion_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk_i      (clock),
        .rst_ni     (resetn),
        .tick_i     (tick),
        .moved_i    (moved),
        .go_o       (go),
        .settling_o (settling),
        .overrun_o  (tick_overrun)
    );

    // Candidate x for this tick: exactly one direction, not blocked, in bounds
    always_comb begin
        x_mv = x_q;
        if (move_left && !move_right) begin
            if (!left_s && (x_ext >= X_LEFT_LIM)) begin
                x_mv = x_q - X_STEP;
            end
        end else if (move_right && !move_left) begin
            if (!right_s && ((x_ext + X_STEP_EXT) <= X_MAX_EXT)) begin
                x_mv = x_q + X_STEP;
            end
        end
    end

    // Candidate vertical state, y and jump counter for this tick
    always_comb begin
        state_mv    = state_q;
        y_mv        = y_q;
        jump_cnt_mv = jump_cnt_q;
        land_mv     = 1'b0;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
        air_used_mv = air_used_q;
`endif
        case (state_q)
            GROUNDED: begin
                if (!down_s) begin
                    state_mv = FALLING;
                end else if (jump_edge && !up_s) begin
                    state_mv    = RISING;
                    jump_cnt_mv = JUMP_TICKS;
                end
            end
            RISING: begin
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
                if (jump_edge && !up_s && !air_used_q) begin
                    jump_cnt_mv = JUMP_TICKS;
                    air_used_mv = 1'b1;
                end else
`endif
                if (up_s || (jump_cnt_q == '0)) begin
                    state_mv = FALLING;
                end else begin
                    y_mv        = y_rise;
                    jump_cnt_mv = jump_cnt_q - 1'b1;
                end
            end
            FALLING: begin
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
                if (jump_edge && !up_s && !air_used_q) begin
                    state_mv    = RISING;
                    jump_cnt_mv = JUMP_TICKS;
                    air_used_mv = 1'b1;
                end else
`endif
                if (down_s) begin
                    state_mv = GROUNDED;
                    land_mv  = 1'b1;
                end else if (y_fall_ext > Y_MAX_EXT) begin
                    // Floor clamp: treat the bottom edge as solid ground
                    y_mv     = Y_MAX;
                    state_mv = GROUNDED;
                    land_mv  = 1'b1;
                end else begin
                    y_mv = y_fall_ext[POS_W-1:0];
                end
            end
            default: begin
                state_mv = FALLING;
            end
        endcase
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
        if (state_mv == GROUNDED) begin
            air_used_mv = 1'b0;
        end
`endif
    end

    // Settle window starts only when the character actually moves
    assign moved = (x_mv != x_q) || (y_mv != y_q);

    // Commit candidates only on the processing clock
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        state_d     = state_q;
        jump_cnt_d  = jump_cnt_q;
        jump_prev_d = jump_prev_q;
        landed_d    = 1'b0;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
        air_used_d  = air_used_q;
`endif
        if (go) begin
            x_d         = x_mv;
            y_d         = y_mv;
            state_d     = state_mv;
            jump_cnt_d  = jump_cnt_mv;
            jump_prev_d = jump;
            landed_d    = land_mv;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
            air_used_d  = air_used_mv;
`endif
        end
    end

    // Motion state registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q         <= X_INIT;
            y_q         <= Y_INIT;
            state_q     <= FALLING;
            jump_cnt_q  <= '0;
            jump_prev_q <= 1'b0;
            landed_q    <= 1'b0;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
            air_used_q  <= 1'b0;
`endif
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            state_q     <= state_d;
            jump_cnt_q  <= jump_cnt_d;
            jump_prev_q <= jump_prev_d;
            landed_q    <= landed_d;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
            air_used_q  <= air_used_d;
`endif
        end
    end

    assign character_x_position = x_q;
    assign character_y_position = y_q;
    assign airborne             = (state_q != GROUNDED);
    assign landed               = landed_q;

endmodule

`default_nettype wire

// File: tb/tb_character_motion.sv
// ============================================================================
// Module      : tb_character_motion
// Description : Self-checking bench for character_motion. A vector table plus
//               hand sequences drive spaced ticks; expected results are
//               queued at drive time and compared after the processing edge.
// Options     : CHARACTER_MOTION_DOUBLE_JUMP_EN selects double-jump
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_character_motion;

    logic       clock = 1'b0;
    logic       resetn;
    logic       tick;
    logic       move_left, move_right, jump;
    logic [2:0] character_down, character_up, character_left, character_right;
    logic [8:0] character_x_position, character_y_position;
    logic       airborne, landed, settling, tick_overrun;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       l, r, j;
        logic [2:0] dn, up, lf, rf;
        logic [8:0] ex, ey;
        logic       ea, el;
    } vec_t;

    typedef struct {
        logic [8:0] x, y;
        logic       air, landed;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   dj_y[6];

    character_motion dut (
        .clock                (clock),
        .resetn               (resetn),
        .tick                 (tick),
        .move_left            (move_left),
        .move_right           (move_right),
        .jump                 (jump),
        .character_down       (character_down),
        .character_up         (character_up),
        .character_left       (character_left),
        .character_right      (character_right),
        .character_x_position (character_x_position),
        .character_y_position (character_y_position),
        .airborne             (airborne),
        .landed               (landed),
        .settling             (settling),
        .tick_overrun         (tick_overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic l, r, j, input logic [2:0] dn, up, lf, rf,
                                input int ex, ey, input logic ea, el);
        vec_t v;
        v.l = l; v.r = r; v.j = j;
        v.dn = dn; v.up = up; v.lf = lf; v.rf = rf;
        v.ex = 9'(ex); v.ey = 9'(ey); v.ea = ea; v.el = el;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        move_left       = v.l;
        move_right      = v.r;
        jump            = v.j;
        character_down  = v.dn;
        character_up    = v.up;
        character_left  = v.lf;
        character_right = v.rf;
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs
    task automatic compare_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check("x",        character_x_position, e.x);
            check("y",        character_y_position, e.y);
            check("airborne", airborne,             e.air);
            check("landed",   landed,               e.landed);
        end
    endtask

    // One tick, compared after its processing edge, then time to settle
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clock);
        drive(v);
        tick = 1'b1;
        e.x = v.ex; e.y = v.ey; e.air = v.ea; e.landed = v.el;
        sb_q.push_back(e);
        @(negedge clock);
        tick = 1'b0;
        compare_front();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Starts at x=20, y=100, FALLING
        vecs[0]  = mk(0,0,0, 3'd1,0,0,0,      20,100, 0,1);
        vecs[1]  = mk(0,1,0, 3'd1,0,0,0,      21,100, 0,0);
        vecs[2]  = mk(0,1,0, 3'd1,0,0,0,      22,100, 0,0);
        vecs[3]  = mk(0,1,0, 3'd1,0,0,0,      23,100, 0,0);
        vecs[4]  = mk(0,1,0, 3'd1,0,0,0,      24,100, 0,0);
        vecs[5]  = mk(0,1,0, 3'd1,0,0,0,      25,100, 0,0);
        vecs[6]  = mk(0,1,0, 3'd1,0,0,3'd2,   25,100, 0,0);
        vecs[7]  = mk(1,1,0, 3'd1,0,0,0,      25,100, 0,0);
        vecs[8]  = mk(1,0,0, 3'd1,0,0,0,      24,100, 0,0);
        vecs[9]  = mk(1,0,0, 3'd1,0,3'd4,0,   24,100, 0,0);
        vecs[10] = mk(0,0,0, 3'd0,0,0,0,      24,100, 1,0);
        vecs[11] = mk(0,0,0, 3'd0,0,0,0,      24,102, 1,0);
        vecs[12] = mk(0,0,0, 3'd7,0,0,0,      24,102, 0,1);
        vecs[13] = mk(0,1,0, 3'd1,3'd1,0,0,   25,102, 0,0);

`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
        dj_y[0] = 76; dj_y[1] = 76; dj_y[2] = 74; dj_y[3] = 74; dj_y[4] = 76; dj_y[5] = 78;
`else
        dj_y[0] = 76; dj_y[1] = 78; dj_y[2] = 80; dj_y[3] = 82; dj_y[4] = 84; dj_y[5] = 86;
`endif

        resetn = 1'b0;
        tick   = 1'b0;
        drive(mk(0,0,0, 0,0,0,0, 0,0, 0,0));
        #12;
        check("rst_x",        character_x_position, 20);
        check("rst_y",        character_y_position, 100);
        check("rst_airborne", airborne,             1);
        check("rst_landed",   landed,               0);
        check("rst_settling", settling,             0);
        check("rst_overrun",  tick_overrun,         0);
        @(negedge clock);
        resetn = 1'b1;

        // Table: landing, right steps, blocked/both, left, fall and land
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
        end

        // Walk left into the x lower bound
        for (int k = 1; k <= 21; k++) begin
            apply(mk(1,0,0, 3'd1,0,0,0, 25-k,102, 0,0));
        end
        apply(mk(1,0,0, 3'd1,0,0,0, 4,102, 0,0));

        // Full jump arc: 12 rising ticks, then fall, then land
        apply(mk(0,0,1, 3'd1,0,0,0, 4,102, 1,0));
        for (int k = 1; k <= 12; k++) begin
            apply(mk(0,0,1, 3'd1,0,0,0, 4,102-2*k, 1,0));
        end
        apply(mk(0,0,1, 3'd1,0,0,0, 4,78, 1,0));
        apply(mk(0,0,0, 3'd1,0,0,0, 4,78, 0,1));
        apply(mk(0,0,0, 3'd1,0,0,0, 4,78, 0,0));

        // Jump cut short by a ceiling after two rising ticks
        apply(mk(0,0,1, 3'd1,0,0,0,    4,78, 1,0));
        apply(mk(0,0,1, 3'd1,0,0,0,    4,76, 1,0));
        apply(mk(0,0,1, 3'd1,0,0,0,    4,74, 1,0));
        apply(mk(0,0,1, 3'd1,3'd4,0,0, 4,74, 1,0));

        // Mid-air jump edges: one re-entry into RISING when enabled
        apply(mk(0,0,0, 3'd0,0,0,0,    4,dj_y[0], 1,0));
        apply(mk(0,0,1, 3'd0,0,0,0,    4,dj_y[1], 1,0));
        apply(mk(0,0,1, 3'd0,0,0,0,    4,dj_y[2], 1,0));
        apply(mk(0,0,1, 3'd0,3'd2,0,0, 4,dj_y[3], 1,0));
        apply(mk(0,0,0, 3'd0,0,0,0,    4,dj_y[4], 1,0));
        apply(mk(0,0,1, 3'd0,0,0,0,    4,dj_y[5], 1,0));
        apply(mk(0,0,0, 3'd1,0,0,0,    4,dj_y[5], 0,1));

        // Back-to-back ticks during the settle window, then an overrun
        @(negedge clock);
        drive(mk(0,1,0, 3'd1,0,0,0, 0,0, 0,0));
        tick = 1'b1;
        @(negedge clock);
        check("settle_x1",   character_x_position, 5);
        check("settle_busy", settling,             1);
        @(negedge clock);
        tick = 1'b0;
        check("pend_hold_x", character_x_position, 5);
        check("pend_ovr0",   tick_overrun,         0);
        @(negedge clock);
        check("settle_done", settling,             0);
        check("pend_wait_x", character_x_position, 5);
        @(negedge clock);
        check("pend_x2",     character_x_position, 6);
        check("pend_busy",   settling,             1);
        tick = 1'b1;
        @(negedge clock);
        check("ovr_before",  tick_overrun,         0);
        @(negedge clock);
        tick = 1'b0;
        check("ovr_set",     tick_overrun,         1);
        check("ovr_x",       character_x_position, 6);
        @(negedge clock);
        check("ovr_pend_x",  character_x_position, 7);
        drive(mk(0,0,0, 3'd1,0,0,0, 0,0, 0,0));
        repeat (4) @(negedge clock);
        check("ovr_sticky",  tick_overrun,         1);
        check("ovr_final_x", character_x_position, 7);

        // Asynchronous reset while rising, with a tick parked in pending
        apply(mk(0,0,1, 3'd1,0,0,0, 7,dj_y[5],   1,0));
        apply(mk(0,0,1, 3'd1,0,0,0, 7,dj_y[5]-2, 1,0));
        @(negedge clock);
        drive(mk(0,1,1, 3'd1,0,0,0, 0,0, 0,0));
        tick = 1'b1;
        @(negedge clock);
        check("pre_rst_x", character_x_position, 8);
        check("pre_rst_y", character_y_position, dj_y[5]-4);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_x",        character_x_position, 20);
        check("arst_y",        character_y_position, 100);
        check("arst_airborne", airborne,             1);
        check("arst_settling", settling,             0);
        check("arst_overrun",  tick_overrun,         0);
        tick = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_x",   character_x_position, 20);
        check("post_rst_y",   character_y_position, 100);
        check("post_rst_air", airborne,             1);

        // Fall from reset to the floor clamp
        for (int k = 1; k <= 62; k++) begin
            apply(mk(0,0,0, 3'd0,0,0,0, 20,100+2*k, 1,0));
        end
        apply(mk(0,0,0, 3'd0,0,0,0, 20,226, 1,0));
        apply(mk(0,0,0, 3'd0,0,0,0, 20,226, 0,1));
        check("clamp_settling", settling, 0);

        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
